fifo_rd_packer: RTL and testbench
=================================

# fifo_rd_packer

Read-side consumer for the dual-clock byte FIFO. It runs entirely in the read clock domain, pops 8-bit entries from the FIFO's show-ahead read port, and packs them little-endian into 32-bit words. Words leave on a valid/ready stream with a byte-keep mask. Partial words are emitted on an explicit flush or after a programmable idle timeout, so downstream logic sees FIFO traffic as words without losing trailing bytes.

## Interface
- TIMEOUT, default 16: number of idle cycles with a partial word held before an automatic flush. Range 0–255; 0 disables the timeout.

Ports:
- rclk  in  1  read-domain clock
- rrst_n  in  1  asynchronous active-low reset
- rempty  in  1  FIFO empty flag, registered in the FIFO
- rdata  in  8  FIFO head byte, valid whenever rempty=0
- rreq  out  1  pop request; the head byte is consumed at the rclk edge where rreq=1
- flush  in  1  single-cycle request to emit any held partial word
- m_valid  out  1  output word valid
- m_ready  in  1  downstream accept
- m_data  out  32  packed word; byte i = i-th byte popped
- m_keep  out  4  byte-valid mask; bit i qualifies m_data[8i+7:8i]

## Operation
- State:
  - acc[23:0]: bytes held
  - cnt[1:0]: 0–3 bytes in acc
  - output register (m_data, m_keep, m_valid)
  - flush_pend
  - idle[7:0]
- Definitions:
  - slot_free = ~m_valid | m_ready
  - flush_eff = flush | flush_pend
- rreq = ~rempty & ~flush_eff & (cnt != 3 | slot_free). This is combinational; no other term gates it.
- Pop with cnt < 3: acc[8·cnt +: 8] <= rdata, then cnt++.
- Pop with cnt = 3: m_data <= {rdata, acc}, m_keep <= 4'b1111, m_valid <= 1, cnt <= 0, acc <= 0.
- Flush, when flush_eff = 1:
  - No pop occurs that cycle.
  - If cnt = 0: clear flush_pend; no output.
  - If cnt > 0 and slot_free: emit m_data <= {8'h00, acc} with unused bytes zero. m_keep is 4'b0001 / 4'b0011 / 4'b0111 for cnt = 1 / 2 / 3. Then cnt <= 0, acc <= 0, flush_pend <= 0.
  - If cnt > 0 and ~slot_free: flush_pend <= 1 and hold until the slot frees.
- Output handshake:
  - A transfer happens on an edge with m_valid & m_ready.
  - m_valid drops after the transfer unless a new word loads in the same edge; back-to-back words are allowed.
  - While m_valid & ~m_ready, m_data and m_keep are held stable.
- Timeout:
  - idle increments each cycle with cnt > 0, no pop and flush_eff = 0.
  - idle clears on any pop, on any flush_eff cycle, or when cnt = 0.
  - When TIMEOUT != 0 and idle reaches TIMEOUT - 1, flush_pend <= 1. The flush takes effect the next cycle.
- Flush takes precedence over pop. A flush starves no one: rreq stays low until the partial word is emitted.

## Timing
- Reset (async, rrst_n low):
  - m_valid = 0, m_data = 0, m_keep = 0
  - cnt = 0, acc = 0, flush_pend = 0, idle = 0
  - Consequently rreq = ~rempty & ~flush.
- Pop-to-output latency: the 4th byte popped at edge N makes m_valid = 1 in the cycle after edge N.
- Sustained throughput: 1 byte per rclk when the FIFO is non-empty and m_ready = 1. This is one word per 4 cycles, with no bubble at the word boundary.
- Flush in cycle N with slot_free: the partial word is visible in cycle N+1.
- Flush in cycle N with the slot blocked: the partial word is visible the cycle after the first accepting edge.
- Timeout with TIMEOUT = T, last pop at edge E: the partial word is visible T+1 cycles after E, provided the slot is free.
- FIFO empty mid-word: bytes are held indefinitely (absent timeout/flush); there is no spurious output.
- cnt = 3, m_valid = 1, m_ready = 0: rreq = 0 and the FIFO head is retained. Popping resumes in the cycle m_ready rises, and that pop completes the word in the same edge as the accept.
- Reset asserted mid-word or mid-handshake discards acc and any pending output. Bytes already popped are lost by design.

## Test plan
- Push 8'h11, 22, 33, 44, 55, 66, 77, 88 with m_ready = 1 -> two words: 32'h44332211 keep 4'hF, then 32'h88776655 keep 4'hF. rreq is high 8 consecutive cycles.
- Push 8'hA1, A2, then pulse flush -> one word 32'h0000A2A1 keep 4'h3, one cycle after flush. A flush with cnt = 0 produces no output.
- Hold m_ready = 0 with 5 bytes queued -> the first word is held stable, rreq = 0 at cnt = 3. Raise m_ready -> the remaining bytes flow, with no loss or duplication.
- TIMEOUT = 4, single byte 8'h5A then the FIFO stays empty -> word 32'h0000005A keep 4'h1 appears 5 cycles after the pop edge. With TIMEOUT = 0, nothing appears within 300 cycles.
- Flush asserted in the same cycle rempty falls, with cnt = 3 and the slot blocked -> no pop occurs; the partial word (keep 4'h7) is emitted after the accept, then the new byte starts the next word.
- Drop rrst_n mid-word (cnt = 2, m_valid = 1) -> all outputs are 0 immediately. After release, a fresh 4-byte sequence packs correctly from byte 0.

Source files
------------

// File: rtl/fifo_rd_packer.sv
// Read-domain consumer for the dual-clock byte FIFO: packs popped bytes little-endian
// into 32-bit words with a keep mask; partial words leave on flush or idle timeout.
module fifo_rd_packer #(
  parameter int unsigned TIMEOUT = 16
) (
  input  logic        rclk,
  input  logic        rrst_n,
  input  logic        rempty,
  input  logic [7:0]  rdata,
  output logic        rreq,
  input  logic        flush,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [31:0] m_data,
  output logic [3:0]  m_keep
);
  localparam bit         TO_EN     = (TIMEOUT != 0);
  localparam logic [7:0] IDLE_LAST = TO_EN ? 8'(TIMEOUT - 1) : 8'd0;

  logic [23:0] acc_q, acc_d;
  logic [1:0]  cnt_q, cnt_d;
  logic [31:0] m_data_q, m_data_d;
  logic [3:0]  m_keep_q, m_keep_d;
  logic        m_valid_q, m_valid_d;
  logic        flush_pend_q, flush_pend_d;
  logic [7:0]  idle_q, idle_d;
  logic        slot_free, flush_eff, pop;

  assign slot_free = ~m_valid_q | m_ready;
  assign flush_eff = flush | flush_pend_q;
  // A full accumulator may only pop when the output slot can take the word this edge.
  assign pop       = ~rempty & ~flush_eff & ((cnt_q != 2'd3) | slot_free);

  assign rreq    = pop;
  assign m_valid = m_valid_q;
  assign m_data  = m_data_q;
  assign m_keep  = m_keep_q;

  always_comb begin
    acc_d        = acc_q;
    cnt_d        = cnt_q;
    m_data_d     = m_data_q;
    m_keep_d     = m_keep_q;
    m_valid_d    = m_valid_q & ~m_ready;
    flush_pend_d = flush_pend_q;
    idle_d       = 8'd0;
    if (flush_eff) begin
      if (cnt_q == 2'd0) begin
        flush_pend_d = 1'b0;
      end else if (slot_free) begin
        // Unfilled acc bytes are already zero, so the padding comes for free.
        m_data_d     = {8'h00, acc_q};
        case (cnt_q)
          2'd1:    m_keep_d = 4'b0001;
          2'd2:    m_keep_d = 4'b0011;
          default: m_keep_d = 4'b0111;
        endcase
        m_valid_d    = 1'b1;
        cnt_d        = 2'd0;
        acc_d        = 24'd0;
        flush_pend_d = 1'b0;
      end else begin
        flush_pend_d = 1'b1;
      end
    end else if (pop) begin
      if (cnt_q == 2'd3) begin
        m_data_d  = {rdata, acc_q};
        m_keep_d  = 4'b1111;
        m_valid_d = 1'b1;
        cnt_d     = 2'd0;
        acc_d     = 24'd0;
      end else begin
        case (cnt_q)
          2'd0:    acc_d[7:0]   = rdata;
          2'd1:    acc_d[15:8]  = rdata;
          default: acc_d[23:16] = rdata;
        endcase
        cnt_d = cnt_q + 2'd1;
      end
    end else if (cnt_q != 2'd0) begin
      idle_d = idle_q + 8'd1;
      if (TO_EN && (idle_q == IDLE_LAST)) flush_pend_d = 1'b1;
    end
  end

  always_ff @(posedge rclk or negedge rrst_n) begin
    if (!rrst_n) begin
      acc_q        <= 24'd0;
      cnt_q        <= 2'd0;
      m_data_q     <= 32'd0;
      m_keep_q     <= 4'd0;
      m_valid_q    <= 1'b0;
      flush_pend_q <= 1'b0;
      idle_q       <= 8'd0;
    end else begin
      acc_q        <= acc_d;
      cnt_q        <= cnt_d;
      m_data_q     <= m_data_d;
      m_keep_q     <= m_keep_d;
      m_valid_q    <= m_valid_d;
      flush_pend_q <= flush_pend_d;
      idle_q       <= idle_d;
    end
  end
endmodule

// File: tb/tb_fifo_rd_packer.sv
// Bench for fifo_rd_packer: a queue-based FIFO and byte-packing model drive and check
// a TIMEOUT=0 instance; a TIMEOUT=4 instance sharing the inputs covers the idle flush.
module tb_fifo_rd_packer;
  logic        rclk = 1'b0, rrst_n = 1'b0, rempty = 1'b1, flush = 1'b0, m_ready = 1'b0;
  logic [7:0]  rdata = 8'd0;
  logic        rreq, m_valid, t_rreq, t_valid;
  logic [31:0] m_data, t_data;
  logic [3:0]  m_keep, t_keep;
  int checks = 0, failures = 0;

  always #5 rclk = ~rclk;

  fifo_rd_packer #(.TIMEOUT(0)) u_nt (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rreq(rreq), .flush(flush),
    .m_valid(m_valid), .m_ready(m_ready), .m_data(m_data), .m_keep(m_keep));

  fifo_rd_packer #(.TIMEOUT(4)) u_to (
    .rclk(rclk), .rrst_n(rrst_n), .rempty(rempty), .rdata(rdata), .rreq(t_rreq), .flush(flush),
    .m_valid(t_valid), .m_ready(m_ready), .m_data(t_data), .m_keep(t_keep));

  logic [7:0]  fq[$];             // FIFO contents
  logic [7:0]  sent[$], got[$];   // bytes entering the FIFO / bytes accepted downstream
  logic [7:0]  hb[$];             // model: bytes popped but not yet in a word
  logic [31:0] gw[$];             // accepted words
  logic [3:0]  gk[$];
  bit          outv = 0, pend = 0;
  logic [31:0] outd = 0;
  logic [3:0]  outk = 0;
  bit          t_v_s;
  logic [31:0] t_d_s;
  logic [3:0]  t_k_s;
  int          streak = 0, max_streak = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic push(input logic [7:0] b);
    fq.push_back(b);
    sent.push_back(b);
  endtask

  function automatic void emit();
    outd = 32'd0;
    foreach (hb[i]) outd[8*i +: 8] = hb[i];
    outk = 4'((1 << hb.size()) - 1);
    outv = 1;
    hb.delete();
  endfunction

  function automatic void model_clear();
    hb.delete(); fq.delete(); sent.delete(); got.delete(); gw.delete(); gk.delete();
    outv = 0; pend = 0;
  endfunction

  // One rclk cycle: drive at negedge, check after settling, advance models at posedge.
  task automatic step(input bit stl, input bit fl, input bit rdy);
    bit slot, fe, exp_rreq, pop_s;
    @(negedge rclk);
    rempty  = stl || (fq.size() == 0);
    rdata   = rempty ? 8'($urandom) : fq[0];
    flush   = fl;
    m_ready = rdy;
    #1;
    slot     = !outv || rdy;
    fe       = fl || pend;
    exp_rreq = !rempty && !fe && (hb.size() != 3 || slot);
    chk("rreq", rreq, exp_rreq);
    chk("m_valid", m_valid, outv);
    if (outv) begin
      chk("m_data", m_data, outd);
      chk("m_keep", m_keep, outk);
    end
    if (m_valid && rdy) begin
      gw.push_back(m_data);
      gk.push_back(m_keep);
      for (int i = 0; i < 4; i++) if (m_keep[i]) got.push_back(m_data[8*i +: 8]);
    end
    t_v_s = t_valid; t_d_s = t_data; t_k_s = t_keep;
    pop_s = rreq;
    streak = pop_s ? streak + 1 : 0;
    if (streak > max_streak) max_streak = streak;
    @(posedge rclk);
    if (pop_s && fq.size() != 0) void'(fq.pop_front());
    if (outv && rdy) outv = 0;
    if (fe) begin
      if (hb.size() == 0) pend = 0;
      else if (slot) begin emit(); pend = 0; end
      else pend = 1;
    end else if (exp_rreq) begin
      hb.push_back(rdata);
      if (hb.size() == 4) emit();
    end
  endtask

  task automatic drain();
    int i;
    i = 0;
    while (i < 3000 && (fq.size() != 0 || hb.size() != 0 || outv || pend)) begin
      step(0, (fq.size() == 0 && hb.size() != 0 && !pend), 1);
      i++;
    end
    chk("drain_done", (fq.size() == 0 && hb.size() == 0 && !outv && !pend), 1);
  endtask

  task automatic check_stream();
    bit same;
    same = (got.size() == sent.size());
    if (same) foreach (sent[i]) if (got[i] !== sent[i]) same = 0;
    chk("byte_count", got.size(), sent.size());
    chk("byte_stream", same, 1);
    got.delete(); sent.delete();
  endtask

  task automatic do_reset();
    @(negedge rclk);
    rrst_n = 0; rempty = 1; flush = 0;
    model_clear();
    @(negedge rclk);
    rrst_n = 1;
  endtask

  initial begin
    // reset values and combinational rreq during reset
    #3;
    chk("rst_m_valid", m_valid, 0);
    chk("rst_m_data", m_data, 0);
    chk("rst_m_keep", m_keep, 0);
    chk("rst_t_valid", t_valid, 0);
    chk("rst_rreq_empty", rreq, 0);
    rempty = 0; #1;
    chk("rst_rreq_avail", rreq, 1);
    flush = 1; #1;
    chk("rst_rreq_flush", rreq, 0);
    rempty = 1; flush = 0;
    @(negedge rclk);
    rrst_n = 1;

    // eight bytes streamed with m_ready high
    max_streak = 0;
    for (int i = 1; i <= 8; i++) push(8'(i * 8'h11));
    repeat (12) step(0, 0, 1);
    chk("a_words", gw.size(), 2);
    chk("a_word0", gw[0], 32'h44332211);
    chk("a_keep0", gk[0], 4'hF);
    chk("a_word1", gw[1], 32'h88776655);
    chk("a_keep1", gk[1], 4'hF);
    chk("a_rreq_run", max_streak, 8);
    check_stream();

    // two bytes then flush; then flush with nothing held
    gw.delete(); gk.delete();
    push(8'hA1); push(8'hA2);
    repeat (2) step(0, 0, 1);
    step(0, 1, 1);
    step(0, 0, 1);
    chk("b_words", gw.size(), 1);
    chk("b_word", gw[0], 32'h0000A2A1);
    chk("b_keep", gk[0], 4'h3);
    step(0, 1, 1);
    repeat (3) step(0, 0, 1);
    chk("b_empty_flush", gw.size(), 1);
    check_stream();

    // backpressure: first word held, popping stops at three held bytes
    for (int i = 0; i < 9; i++) push(8'hC0 + 8'(i));
    repeat (8) step(0, 0, 0);
    chk("c_fifo_retained", fq.size(), 2);
    chk("c_held_data", m_data, 32'hC3C2C1C0);
    drain();
    check_stream();

    // flush coinciding with rempty falling while cnt=3 and the slot is blocked
    gw.delete(); gk.delete();
    for (int i = 0; i < 7; i++) push(8'hB1 + 8'(i));
    repeat (8) step(0, 0, 0);
    push(8'hE1);
    step(0, 1, 0);
    chk("d_no_pop", fq.size(), 1);
    repeat (2) step(0, 0, 0);
    chk("d_still_held", fq.size(), 1);
    repeat (3) step(0, 0, 1);
    drain();
    chk("d_words", gw.size(), 3);
    chk("d_word1", gw[1], 32'h00B7B6B5);
    chk("d_keep1", gk[1], 4'h7);
    chk("d_word2", gw[2], 32'h000000E1);
    check_stream();

    // asynchronous reset with cnt=2 and a word held
    gw.delete(); gk.delete();
    for (int i = 0; i < 6; i++) push(8'h60 + 8'(i));
    repeat (6) step(0, 0, 0);
    #2;
    rrst_n = 0; rempty = 0; flush = 0; #1;
    chk("e_m_valid", m_valid, 0);
    chk("e_m_data", m_data, 0);
    chk("e_m_keep", m_keep, 0);
    chk("e_rreq", rreq, 1);
    flush = 1; #1;
    chk("e_rreq_flush", rreq, 0);
    model_clear();
    @(negedge rclk);
    rrst_n = 1; rempty = 1; flush = 0;
    for (int i = 0; i < 4; i++) push(8'hD0 + 8'(i));
    repeat (6) step(0, 0, 1);
    chk("e_words", gw.size(), 1);
    chk("e_word", gw[0], 32'hD3D2D1D0);
    check_stream();

    // idle timeout: TIMEOUT=4 emits on the 6th sampled cycle, TIMEOUT=0 never
    do_reset();
    push(8'h5A);
    step(0, 0, 1);
    for (int k = 1; k <= 6; k++) begin
      step(0, 0, 0);
      chk("to_valid", t_v_s, (k == 6));
    end
    chk("to_data", t_d_s, 32'h0000005A);
    chk("to_keep", t_k_s, 4'h1);
    repeat (300) step(0, 0, 0);
    chk("nt_no_output", gw.size(), 0);
    drain();
    check_stream();

    // randomized traffic, stalls, backpressure and flushes
    do_reset();
    for (int n = 0; n < 500; n++) begin
      int r;
      r = int'($urandom_range(0, 4));
      if (r == 0) push(8'($urandom));
      if (r == 1) begin push(8'($urandom)); push(8'($urandom)); end
      step($urandom_range(0, 3) == 0, $urandom_range(0, 15) == 0, $urandom_range(0, 2) != 0);
    end
    drain();
    check_stream();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
